// File: rtl/alu_trace_capture.sv
// alu_trace_capture: captures qualified ALU result/flag samples into a
// first-word-fall-through FIFO during an armed session. The session ends
// when an accepted sample carries MATCH_VALUE. The FIFO is readable in
// every state, and its contents survive re-arming.
module alu_trace_capture #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] MATCH_VALUE = 32'd100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     cap_en,
  input  logic [31:0]              alu_result,
  input  logic [3:0]               alu_flags,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_result,
  output logic [3:0]               rd_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [1:0]               state,
  output logic                     match_hit,
  output logic [15:0]              match_cycle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [15:0]     cyc_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_q;
  logic [35:0]     mem [DEPTH];

  logic push_req;
  logic push_ok;
  logic pop;
  logic is_match;
  logic arm_ok;

  // Read handshake: rd_valid is high whenever the FIFO holds an entry and
  // rd_result/rd_flags then show the head entry. The head is consumed on a
  // rising edge where rd_valid && rd_ready; rd_ready alone never has effect.
  // rd_valid does not depend on rd_ready.
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign rd_valid  = !empty;
  assign rd_result = mem[rd_ptr][31:0];
  assign rd_flags  = mem[rd_ptr][35:32];
  assign count     = count_q;
  assign state     = state_q;

  // Decode this cycle's push/pop/match/arm events
  always_comb begin
    pop      = rd_valid && rd_ready;
    push_req = (state_q == ST_ARMED) && cap_en;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop);
    is_match = push_ok && (alu_result == MATCH_VALUE);
    // arm only has meaning outside an active session.
    arm_ok   = arm && (state_q != ST_ARMED);
  end

  // Store accepted samples; storage is not reset because pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {alu_flags, alu_result};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Session FSM with sticky overflow/match status and armed-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cyc_cnt     <= '0;
      overflow    <= 1'b0;
      match_hit   <= 1'b0;
      match_cycle <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_ok) begin
            state_q     <= ST_ARMED;
            cyc_cnt     <= '0;
            overflow    <= 1'b0;
            match_hit   <= 1'b0;
            match_cycle <= '0;
          end
        end
        ST_ARMED: begin
          if (cyc_cnt != 16'hFFFF) begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
          // A dropped sample only marks overflow; it can never end the session.
          if (push_req && !push_ok) begin
            overflow <= 1'b1;
          end
          if (is_match) begin
            match_hit   <= 1'b1;
            match_cycle <= cyc_cnt;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (arm_ok) begin
            state_q     <= ST_ARMED;
            cyc_cnt     <= '0;
            overflow    <= 1'b0;
            match_hit   <= 1'b0;
            match_cycle <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_trace_capture.sv
// tb_alu_trace_capture: directed stimulus against a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_alu_trace_capture;

  localparam int DEPTH = 16;
  localparam logic [31:0] MATCH = 32'd100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        cap_en = 1'b0;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_result;
  logic [3:0]  rd_flags;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [1:0]  state;
  logic        match_hit;
  logic [15:0] match_cycle;

  always #5 clk = ~clk;

  alu_trace_capture #(.DEPTH(DEPTH), .MATCH_VALUE(MATCH)) dut (
    .clk(clk), .reset(reset), .arm(arm), .cap_en(cap_en),
    .alu_result(alu_result), .alu_flags(alu_flags), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_result(rd_result), .rd_flags(rd_flags),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .state(state), .match_hit(match_hit), .match_cycle(match_cycle)
  );

  // ---------------- scoreboard counters ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // ---------------- reference model ----------------
  logic [35:0] exp_q[$];
  int          m_state = 0;
  bit          m_overflow = 0;
  bit          m_match_hit = 0;
  int          m_match_cycle = 0;
  int          m_cyc = 0;
  bit          started = 0;

  always @(posedge clk) begin
    bit pop_now;
    bit push_req;
    bit accept;
    bit was_armed;
    started = 1;
    if (reset) begin
      exp_q.delete();
      m_state = 0; m_overflow = 0; m_match_hit = 0; m_match_cycle = 0; m_cyc = 0;
    end else begin
      was_armed = (m_state == 1);
      pop_now   = (exp_q.size() > 0) && rd_ready;
      push_req  = was_armed && cap_en;
      accept    = push_req && ((exp_q.size() < DEPTH) || pop_now);
      if (pop_now) void'(exp_q.pop_front());
      if (accept) exp_q.push_back({alu_flags, alu_result});
      if (push_req && !accept) m_overflow = 1;
      if (accept && alu_result == MATCH) begin
        m_match_hit = 1; m_match_cycle = m_cyc; m_state = 2;
      end
      if (was_armed && m_cyc < 65535) m_cyc = m_cyc + 1;
      if (arm && !was_armed) begin
        m_state = 1; m_overflow = 0; m_match_hit = 0; m_match_cycle = 0; m_cyc = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("rd_valid", rd_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("rd_result", rd_result, exp_q[0][31:0]);
        check("rd_flags", rd_flags, exp_q[0][35:32]);
      end
      check("count", count, exp_q.size());
      check("full", full, exp_q.size() == DEPTH);
      check("empty", empty, exp_q.size() == 0);
      check("overflow", overflow, m_overflow);
      check("state", state, m_state);
      check("match_hit", match_hit, m_match_hit);
      check("match_cycle", match_cycle, m_match_cycle);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v, input logic [3:0] f, input logic rr);
    cap_en = 1'b1; alu_result = v; alu_flags = f; rd_ready = rr;
    tick();
    cap_en = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [31:0] v);
    @(negedge clk);
    check(name, rd_result, v);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] seq37[3];
    seq37[0] = 32'd96; seq37[1] = 32'd97; seq37[2] = 32'd100;

    // Reset two cycles with cap_en high, then samples without arm
    reset = 1'b1; cap_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_result = 32'd5 + i; alu_flags = 4'(i);
      tick();
    end
    cap_en = 1'b0;
    @(negedge clk);
    check("noarm_count", count, 0);
    check("noarm_state", state, 0);
    check("noarm_rd_valid", rd_valid, 0);

    // Arm, capture 96,97,100 -> session ends on the match sample
    pulse_arm();
    for (int i = 0; i < 3; i++) push(seq37[i], 4'(i + 1), 1'b0);
    push(32'd100, 4'hF, 1'b0);
    push(32'd55, 4'hE, 1'b0);
    @(negedge clk);
    check("match_count", count, 3);
    check("match_hit_lit", match_hit, 1);
    check("match_cycle_lit", match_cycle, 2);
    check("match_state", state, 2);
    for (int i = 0; i < 3; i++) pop_expect("match_read", seq37[i]);
    @(negedge clk);
    check("match_drained", empty, 1);

    // Re-arm, 17 non-matching pushes with no reads -> one dropped
    pulse_arm();
    for (int i = 1; i <= 17; i++) push(32'd1000 + i, 4'(i), 1'b0);
    @(negedge clk);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_overflow", overflow, 1);
    check("fill_head", rd_result, 32'd1001);

    // Rejected match value while full does not end the session
    push(32'd100, 4'h5, 1'b0);
    @(negedge clk);
    check("rej_overflow", overflow, 1);
    check("rej_match_hit", match_hit, 0);
    check("rej_state", state, 1);
    check("rej_count", count, 16);

    // Match value pushed into a full FIFO while the head pops
    push(32'd100, 4'h6, 1'b1);
    @(negedge clk);
    check("fullpop_count", count, 16);
    check("fullpop_match_hit", match_hit, 1);
    check("fullpop_state", state, 2);
    for (int i = 2; i <= 16; i++) pop_expect("fullpop_read", 32'd1000 + i);
    pop_expect("fullpop_tail", 32'd100);
    @(negedge clk);
    check("fullpop_empty", empty, 1);

    // Streaming with overlapping push/pop and an ignored mid-session arm
    pulse_arm();
    for (int i = 0; i < 24; i++) begin
      cap_en = (i % 4 != 3);
      alu_result = 32'd4000 + i; alu_flags = 4'(i);
      rd_ready = (i % 3 != 0);
      arm = (i == 10);
      tick();
    end
    cap_en = 1'b0; arm = 1'b0;
    rd_ready = 1'b1;
    repeat (20) tick();
    rd_ready = 1'b0;
    @(negedge clk);
    check("stream_state", state, 1);
    check("stream_empty", empty, 1);

    // Five entries mid-session, then reset (with arm/push/pop asserted)
    for (int i = 0; i < 5; i++) push(32'd3000 + i, 4'(i), 1'b0);
    @(negedge clk);
    check("pre_reset_count", count, 5);
    reset = 1'b1; arm = 1'b1; cap_en = 1'b1; rd_ready = 1'b1; alu_result = 32'd100;
    tick();
    reset = 1'b0; arm = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_match_hit", match_hit, 0);
    check("rst_match_cycle", match_cycle, 0);

    // Arm and match on the first armed cycle
    pulse_arm();
    push(32'd100, 4'h9, 1'b0);
    @(negedge clk);
    check("post_count", count, 1);
    check("post_match_cycle", match_cycle, 0);
    check("post_match_hit", match_hit, 1);
    check("post_state", state, 2);
    check("post_head", rd_result, 32'd100);
    check("post_flags", rd_flags, 4'h9);

    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_trace_capture.md
ALU_TRACE_CAPTURE -- requirements
Module: alu_trace_capture

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two, >=2).
REQ-002 Parameter MATCH_VALUE, default 32'd100, ALU result that ends capture.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 arm  input  1  pulse; starts capture session.
REQ-006 cap_en  input  1  sample-qualify strobe for current ALU outputs.
REQ-007 alu_result  input  32  ALUResult from TOP.
REQ-008 alu_flags  input  4  ALUFlags from TOP (NZCV).
REQ-009 rd_ready  input  1  consumer accepts head entry.
REQ-010 rd_valid  output  1  head entry available.
REQ-011 rd_result  output  32  head entry result field.
REQ-012 rd_flags  output  4  head entry flags field.
REQ-013 count  output  $clog2(DEPTH)+1  entries stored.
REQ-014 full, empty  output  1 each  count==DEPTH, count==0.
REQ-015 overflow  output  1  sticky: a capture was dropped.
REQ-016 state  output  2  IDLE=0, ARMED=1, DONE=2.
REQ-017 match_hit  output  1  sticky: MATCH_VALUE captured this session.
REQ-018 match_cycle  output  16  ARMED-cycle index of the match sample.

Function
REQ-019 FSM: IDLE -arm-> ARMED; ARMED -match push-> DONE; DONE -arm-> ARMED; no other transitions; arm in ARMED ignored.
REQ-020 Push request = state==ARMED && cap_en; entry = {alu_flags, alu_result} sampled that edge.
REQ-021 Push accepted if !full, or if full and pop occurs same cycle.
REQ-022 Rejected push: entry discarded, overflow set to 1, state/match logic not advanced by that sample.
REQ-023 Match: accepted push with alu_result==MATCH_VALUE -> match_hit=1, match_cycle=cyc_cnt, state DONE next cycle; that entry is stored.
REQ-024 Rejected push carrying MATCH_VALUE does not trigger match.
REQ-025 cyc_cnt: 16-bit, cleared on arm, +1 each ARMED cycle, saturates at 16'hFFFF; first ARMED cycle index 0.
REQ-026 Read: first-word fall-through; rd_valid=!empty; rd_result/rd_flags = head entry combinationally; undefined-but-stable when empty.
REQ-027 Pop = rd_valid && rd_ready; rd_ready with empty FIFO has no effect.
REQ-028 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-029 Pointers wrap modulo DEPTH; count range 0..DEPTH, never exceeds DEPTH.
REQ-030 arm (from IDLE or DONE) clears overflow, match_hit, match_cycle, cyc_cnt; FIFO contents retained and remain readable.
REQ-031 Reads permitted in every state; DONE never pushes.
REQ-032 Latency: pushed entry visible on rd_valid the cycle after the push edge.

Reset
REQ-033 reset=1 at rising edge: state=IDLE, count=0, pointers=0, empty=1, full=0, rd_valid=0, overflow=0, match_hit=0, match_cycle=0, cyc_cnt=0.
REQ-034 reset overrides arm, push and pop in the same cycle, including mid-session; stored entries are lost.
REQ-035 After reset deasserts, no push until arm is seen.

Verification
REQ-036 reset 2 cycles, cap_en=1, no arm, results 5,6,7 -> count=0, state=IDLE, rd_valid=0.
REQ-037 arm, then results 96,97,100 with cap_en=1, rd_ready=0 -> count=3, match_hit=1, match_cycle=2, state=DONE; further cap_en ignored; reads return 96,97,100 in order.
REQ-038 DEPTH=16, arm, 17 non-matching pushes, rd_ready=0 -> full=1, count=16, overflow=1; 17th value absent; 16 pops return pushes 1..16.
REQ-039 Full FIFO, push 100 with rd_ready=1 same cycle -> push accepted, count stays 16, match_hit=1, state=DONE.
REQ-040 Rejected push of 100 while full, rd_ready=0 -> overflow=1, match_hit=0, state remains ARMED.
REQ-041 ARMED with count=5, assert reset one cycle -> all REQ-033 values next cycle; subsequent arm and push of 100 -> count=1, match_cycle=0.
